// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with frame-synchronous input latching,
// leading-zero blanking, a digit enable mask and 16-level PWM brightness.
module ssd_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   mask_in,
  input  logic                    blank_lz_in,
  input  logic [3:0]              brightness_in,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_out
);

  localparam int TW = $clog2(DIGIT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int OW = $clog2(DIGIT_CYCLES) + 5;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic          POL       = (ACTIVE_LOW != 0);

  logic [TW-1:0]             r_tick;
  logic [IW-1:0]             r_idx;
  logic                      r_first;
  logic [4*NUM_DIGITS-1:0]   r_val;
  logic [NUM_DIGITS-1:0]     r_dp;
  logic [NUM_DIGITS-1:0]     r_mask;
  logic                      r_blankLz;
  logic [OW-1:0]             r_onCycles;
  logic [NUM_DIGITS-1:0]     r_anOut;
  logic [6:0]                r_catOut;
  logic                      r_dpOut;
  logic                      r_frameOut;

  logic                      w_latch;
  logic [OW-1:0]             w_onProd;
  logic [NUM_DIGITS-1:0]     w_zeroFrom;
  logic                      w_blanked;
  logic                      w_lit;
  logic [3:0]                w_nibble;
  logic [6:0]                w_seg;
  logic [NUM_DIGITS-1:0]     w_anHot;

  function automatic logic [6:0] hexDecode(input logic [3:0] nib);
    case (nib)
      4'h0: hexDecode = 7'h3F;  4'h1: hexDecode = 7'h06;
      4'h2: hexDecode = 7'h5B;  4'h3: hexDecode = 7'h4F;
      4'h4: hexDecode = 7'h66;  4'h5: hexDecode = 7'h6D;
      4'h6: hexDecode = 7'h7D;  4'h7: hexDecode = 7'h07;
      4'h8: hexDecode = 7'h7F;  4'h9: hexDecode = 7'h6F;
      4'hA: hexDecode = 7'h77;  4'hB: hexDecode = 7'h7C;
      4'hC: hexDecode = 7'h39;  4'hD: hexDecode = 7'h5E;
      4'hE: hexDecode = 7'h79;  default: hexDecode = 7'h71;
    endcase
  endfunction

  // The first cycle after reset only latches; the scan is held at tick 0 so every frame is full length.
  assign w_latch  = r_first | ((r_tick == TICK_LAST) & (r_idx == IDX_LAST));
  assign w_onProd = OW'({1'b0, brightness_in} + 5'd1) * OW'(DIGIT_CYCLES);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tick  <= '0;
      r_idx   <= '0;
      r_first <= 1'b1;
    end else if (r_first) begin
      r_first <= 1'b0;
    end else if (r_tick == TICK_LAST) begin
      r_tick <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_val      <= '0;
      r_dp       <= '0;
      r_mask     <= '0;
      r_blankLz  <= 1'b0;
      r_onCycles <= OW'(DIGIT_CYCLES >> 4);
    end else if (w_latch) begin
      r_val      <= val_in;
      r_dp       <= dp_in;
      r_mask     <= mask_in;
      r_blankLz  <= blank_lz_in;
      r_onCycles <= w_onProd >> 4;
    end
  end

  always_comb begin
    w_zeroFrom = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_zeroFrom[i] = ((r_val >> (4 * i)) == '0);
    end
  end

  assign w_blanked = r_blankLz & (r_idx != '0) & w_zeroFrom[r_idx];
  assign w_lit     = r_mask[r_idx] & ~w_blanked & (OW'(r_tick) < r_onCycles);
  assign w_nibble  = r_val[r_idx*4 +: 4];
  assign w_seg     = hexDecode(w_nibble);
  assign w_anHot   = NUM_DIGITS'(1) << r_idx;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_anOut    <= {NUM_DIGITS{POL}};
      r_catOut   <= {7{POL}};
      r_dpOut    <= POL;
      r_frameOut <= 1'b0;
    end else begin
      r_anOut    <= (w_lit ? w_anHot : '0) ^ {NUM_DIGITS{POL}};
      r_catOut   <= (w_lit ? w_seg : 7'h00) ^ {7{POL}};
      r_dpOut    <= (w_lit & r_dp[r_idx]) ^ POL;
      r_frameOut <= w_latch;
    end
  end

  assign an_out    = r_anOut;
  assign cat_out   = r_catOut;
  assign dp_out    = r_dpOut;
  assign frame_out = r_frameOut;

endmodule
